pkt_rr_scheduler: RTL
=====================

PKT_RR_SCHEDULER -- requirements
Module: pkt_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of ingress AXIS requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 64, beat width (one RAM frame).
REQ-003 SHALL have parameter KEEP_W, default DATA_W/8, byte-enable width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports s_axis_rx_tvalid_i / tready_o / tlast_i  input/output/input  NUM_PORTS each  per-requester handshake and end of packet.
REQ-007 SHALL have ports s_axis_rx_tdata_i / tkeep_i  input  NUM_PORTS*DATA_W / NUM_PORTS*KEEP_W  packed per requester, port 0 in LSBs.
REQ-008 SHALL have ports m_axis_tx_tvalid_o, tdata_o, tkeep_o, tlast_o  output  1/DATA_W/KEEP_W/1  egress to parser.
REQ-009 SHALL have port m_axis_tx_tready_i  input  1  egress backpressure.
REQ-010 SHALL have port cfg_port_en_i  input  NUM_PORTS  per-requester enable mask.
REQ-011 SHALL have ports grant_o  output  clog2(NUM_PORTS)  current grant, and busy_o  output  1  packet in progress.
REQ-012 SHALL have port pkt_cnt_o  output  32  packets forwarded since reset.

Function
REQ-013 SHALL arbitrate at packet granularity; once granted, a requester holds the egress until its tlast beat is accepted.
REQ-014 SHALL use FSM states IDLE and XFER only.
REQ-015 IDLE: SHALL grant the first enabled requester with tvalid=1, searching from (last_grant+1) mod NUM_PORTS upward with wrap; grant registered; SHALL go to XFER next cycle.
REQ-016 IDLE with no enabled valid requester SHALL remain in IDLE, grant_o unchanged.
REQ-017 XFER: s_axis_rx_tready_o SHALL be 1 only for the granted port and only when the skid buffer can accept; all others 0.
REQ-018 XFER: on granted beat accepted with tlast=1, SHALL return to IDLE; last_grant := grant; pkt_cnt_o += 1 (wraps at 2^32).
REQ-019 Arbitration bubble SHALL be exactly one cycle (IDLE) between consecutive packets.
REQ-020 Egress SHALL pass through a 2-entry skid buffer: latency 1 cycle input accept to m_axis_tx_tvalid_o, full throughput (1 beat/cycle) under continuous tready.
REQ-021 Egress SHALL hold tdata/tkeep/tlast stable while tvalid=1 and tready=0.
REQ-022 Clearing a cfg_port_en_i bit mid-packet SHALL NOT abort that packet; it only excludes the port from subsequent arbitration.
REQ-023 A requester that deasserts tvalid mid-packet SHALL keep its grant (no timeout).
REQ-024 busy_o SHALL be 1 in XFER, 0 in IDLE.
REQ-025 Beats with tkeep=0 SHALL be forwarded unchanged; the block SHALL NOT inspect payload.

Reset
REQ-026 On resetn=0: state IDLE, all tready_o=0, m_axis_tx_tvalid_o=0, tlast_o=0, tdata_o/tkeep_o=0, grant_o=NUM_PORTS-1 (so port 0 wins first), busy_o=0, pkt_cnt_o=0, skid buffer empty.
REQ-027 Reset mid-packet SHALL discard buffered beats; downstream sees a truncated packet without tlast (accepted behaviour).

Structure
REQ-028 NUM_PORTS/DATA_W/KEEP_W defaults and state enum SHALL live in shared package tb_defs-compatible pkt_sched_pkg.
REQ-029 Skid buffer SHALL be a separate sub-module axis_skid_buf (parameter DATA_W, KEEP_W).

Verification
REQ-030 Ports 0..3 each 3-beat packet, all valid at once, tready=1 -> egress order 0,1,2,3; 12 beats, 3 bubble cycles, pkt_cnt_o=4.
REQ-031 Port 2 only, 5-beat packet, m_axis_tx_tready_i toggling 1,0 -> 5 beats in order, data stable during stalls, tlast on beat 5.
REQ-032 Port 1 mid-packet, cfg_port_en_i[1] cleared after beat 2 of 4 -> all 4 beats forwarded; later port 1 packet never granted.
REQ-033 Port 0 sends 2 packets back-to-back while port 3 waits -> order 0,3,0.
REQ-034 resetn pulsed low during beat 3 of 6 -> all outputs reset values within same cycle (asynchronous); next packet from port 0 granted first.
REQ-035 2^32-1 preload via force then one packet -> pkt_cnt_o wraps to 0.

Source files
------------

// File: rtl/pkt_sched_pkg.sv
`default_nettype none
// ============================================================================
// pkt_sched_pkg : shared defaults and FSM state type for pkt_rr_scheduler
// Rev 1.0
// ============================================================================
package pkt_sched_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int DATA_W_DEF    = 64;
  localparam int KEEP_W_DEF    = DATA_W_DEF / 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/axis_skid_buf.sv
`default_nettype none
// ============================================================================
// axis_skid_buf : 2-entry AXI-Stream skid buffer, registered ready and valid
// Rev 1.0
// ============================================================================
module axis_skid_buf
  import pkt_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [KEEP_W-1:0] s_keep_i,
  input  logic              s_last_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic [KEEP_W-1:0] m_keep_o,
  output logic              m_last_o,
  input  logic              m_ready_i
);

  localparam int PAY_W = DATA_W + KEEP_W + 1;

  logic             out_valid_q, out_valid_d;
  logic [PAY_W-1:0] out_pay_q, out_pay_d;
  logic             skid_valid_q, skid_valid_d;
  logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
  logic [PAY_W-1:0] in_pay;
  logic             in_fire;

  assign in_pay    = {s_data_i, s_keep_i, s_last_i};
  assign s_ready_o = ~skid_valid_q;
  assign in_fire   = s_valid_i & ~skid_valid_q;

  // The skid entry only fills when the output stage is stalled, so it always
  // drains first to keep beat order.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pay_d    = out_pay_q;
    skid_valid_d = skid_valid_q;
    skid_pay_d   = skid_pay_q;
    if (!out_valid_q || m_ready_i) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pay_d    = skid_pay_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_pay_d = in_pay;
        end
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_pay_d   = in_pay;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_pay_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_pay_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pay_q    <= out_pay_d;
      skid_valid_q <= skid_valid_d;
      skid_pay_q   <= skid_pay_d;
    end
  end

  assign m_valid_o = out_valid_q;
  assign {m_data_o, m_keep_o, m_last_o} = out_pay_q;

endmodule
`default_nettype wire

// File: rtl/pkt_rr_scheduler.sv
`default_nettype none
// ============================================================================
// pkt_rr_scheduler : packet-granular round-robin AXIS arbiter with skid egress
// Rev 1.0
// ============================================================================
module pkt_rr_scheduler
  import pkt_sched_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int KEEP_W    = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_PORTS-1:0]          s_axis_rx_tvalid_i,
  output logic [NUM_PORTS-1:0]          s_axis_rx_tready_o,
  input  logic [NUM_PORTS-1:0]          s_axis_rx_tlast_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_rx_tdata_i,
  input  logic [NUM_PORTS*KEEP_W-1:0]   s_axis_rx_tkeep_i,
  output logic                          m_axis_tx_tvalid_o,
  output logic [DATA_W-1:0]             m_axis_tx_tdata_o,
  output logic [KEEP_W-1:0]             m_axis_tx_tkeep_o,
  output logic                          m_axis_tx_tlast_o,
  input  logic                          m_axis_tx_tready_i,
  input  logic [NUM_PORTS-1:0]          cfg_port_en_i,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_o,
  output logic                          busy_o,
  output logic [31:0]                   pkt_cnt_o
);

  localparam int                 GRANT_W = $clog2(NUM_PORTS);
  localparam logic [GRANT_W:0]   PORTS_W = (GRANT_W + 1)'(NUM_PORTS);
  localparam logic [GRANT_W:0]   ONE_W   = (GRANT_W + 1)'(1);

  sched_state_e          state_q, state_d;
  logic [GRANT_W-1:0]    grant_q, grant_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;

  logic [NUM_PORTS-1:0]   req, req_rot, grant_onehot;
  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [GRANT_W:0]       rot_base, rr_sum;
  logic [GRANT_W-1:0]     rr_offset, rr_winner;
  logic                   sel_valid, sel_last, skid_ready, beat_fire;
  logic [DATA_W-1:0]      sel_data;
  logic [KEEP_W-1:0]      sel_keep;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-set-bit pick starting just above the previous grant.
  assign req      = s_axis_rx_tvalid_i & cfg_port_en_i;
  assign req_dbl  = {req, req};
  assign rot_base = {1'b0, grant_q} + ONE_W;

  always_comb begin
    req_rot   = req_dbl[rot_base +: NUM_PORTS];
    rr_offset = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rr_offset = GRANT_W'(i);
      end
    end
    rr_sum    = rot_base + {1'b0, rr_offset};
    rr_winner = (rr_sum >= PORTS_W) ? GRANT_W'(rr_sum - PORTS_W) : GRANT_W'(rr_sum);
  end

  always_comb begin
    grant_onehot = '0;
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    sel_data     = '0;
    sel_keep     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q == GRANT_W'(p)) begin
        grant_onehot[p] = 1'b1;
        sel_valid       = s_axis_rx_tvalid_i[p];
        sel_last        = s_axis_rx_tlast_i[p];
        sel_data        = s_axis_rx_tdata_i[p*DATA_W +: DATA_W];
        sel_keep        = s_axis_rx_tkeep_i[p*KEEP_W +: KEEP_W];
      end
    end
  end

  assign beat_fire = (state_q == ST_XFER) & sel_valid & skid_ready;

  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    pkt_cnt_d          = pkt_cnt_q;
    s_axis_rx_tready_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = rr_winner;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        s_axis_rx_tready_o = skid_ready ? grant_onehot : '0;
        if (beat_fire && sel_last) begin
          state_d   = ST_IDLE;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      grant_q   <= GRANT_W'(NUM_PORTS - 1);
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  axis_skid_buf #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .s_valid_i ((state_q == ST_XFER) & sel_valid),
    .s_ready_o (skid_ready),
    .s_data_i  (sel_data),
    .s_keep_i  (sel_keep),
    .s_last_i  (sel_last),
    .m_valid_o (m_axis_tx_tvalid_o),
    .m_data_o  (m_axis_tx_tdata_o),
    .m_keep_o  (m_axis_tx_tkeep_o),
    .m_last_o  (m_axis_tx_tlast_o),
    .m_ready_i (m_axis_tx_tready_i)
  );

  assign grant_o   = grant_q;
  assign busy_o    = (state_q == ST_XFER);
  assign pkt_cnt_o = pkt_cnt_q;

endmodule
`default_nettype wire
